// File: rtl/cradr_seq.sv
// -----------------------------------------------------------------------------
// cradr_seq -- control-RAM address sequencer
//
// Produces the registered CRAM address (CRADR) once per unstalled cycle from
// the microinstruction jump field, an optional dispatch OR-field, a small
// CALL/RETURN stack and a page-fail trap that forces the address to all ones.
//
// Next-address priority: diagJump > force1777 > ret > default (J | dispatch).
//
// Optional feature: define CRADR_SEQ_DIAG_EN to build the diagnostic path
// (diagAdr load from EBUS, diagnostic jump, one-cycle EBUS readback of CRADR).
// Without it the diagnostic inputs are ignored and the EBUS outputs are tied 0.
//
// Ports
//   clk          sole clock, rising edge
//   resetN       asynchronous active-low reset
//   hold         stall; freezes sequencer state (diag load/readback still run)
//   J            jump field
//   dispEn       OR dispVal into the low bits of the next address
//   dispVal      dispatch value
//   call / ret   push current address / pop and return
//   force1777    page-fail trap: next address = all ones, push current address
//   diagLoad     load diagAdr from ebusIn[36-ADR_W:35]
//   diagJump     take diagAdr as next address
//   diagRead     request EBUS readback of CRADR on the next cycle
//   ebusIn       EBUS data, bit 0 is the MSB, bit 35 the LSB
//   CRADR        current CRAM address
//   sbrRet       stack top, 0 when the stack is empty
//   depth        stack occupancy
//   stackOvf     sticky overflow flag
//   stackUnf     sticky underflow flag
//   dispParity   registered XOR of {call, ret, dispEn, dispVal}
//   drivingEBUS  high while ebusOut carries readback data
//   ebusOut      readback data, CRADR right-justified at bit 35
// -----------------------------------------------------------------------------
module cradr_seq #(
    parameter int ADR_W       = 11,
    parameter int STACK_DEPTH = 8,
    parameter int DISP_W      = 5
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         hold,
    input  logic [ADR_W-1:0]             J,
    input  logic                         dispEn,
    input  logic [DISP_W-1:0]            dispVal,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         force1777,
    input  logic                         diagLoad,
    input  logic                         diagJump,
    input  logic                         diagRead,
    input  logic [0:35]                  ebusIn,
    output logic [ADR_W-1:0]             CRADR,
    output logic [ADR_W-1:0]             sbrRet,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         stackOvf,
    output logic                         stackUnf,
    output logic                         dispParity,
    output logic                         drivingEBUS,
    output logic [0:35]                  ebusOut
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int DEP_W = PTR_W + 1;
    localparam logic [DEP_W-1:0] DEPTH_FULL = DEP_W'(STACK_DEPTH);

    // Sequencer state
    logic [ADR_W-1:0] cradr_reg;
    logic [ADR_W-1:0] stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0] top_reg;      // index of the current top entry
    logic [DEP_W-1:0] depth_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic             parity_reg;

    // Decoded control for this cycle
    logic [ADR_W-1:0] adr_next;
    logic [ADR_W-1:0] disp_ext;
    logic [ADR_W-1:0] top_val;
    logic [PTR_W-1:0] top_inc;
    logic             stack_empty;
    logic             stack_full;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             set_unf;

`ifdef CRADR_SEQ_DIAG_EN
    logic [ADR_W-1:0] diag_adr_reg;
    logic             drive_reg;
    logic [0:35]      ebus_out_reg;
`endif

    assign disp_ext    = ADR_W'(dispVal);
    assign top_val     = stack_mem[top_reg];
    assign top_inc     = top_reg + 1'b1;
    assign stack_empty = (depth_reg == '0);
    assign stack_full  = (depth_reg == DEPTH_FULL);

    always_comb begin
        adr_next   = dispEn ? (J | disp_ext) : J;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;
        set_unf    = 1'b0;
        if (force1777) begin
            // Trap: save the faulting address; a concurrent ret is ignored.
            adr_next = '1;
            do_push  = 1'b1;
        end else if (ret) begin
            if (stack_empty) begin
                // Nothing to return to: fall through to J. A concurrent call
                // has no top entry to replace, so the stack is left untouched.
                adr_next = J;
                set_unf  = 1'b1;
            end else begin
                adr_next = top_val | J;
                if (call) begin
                    do_replace = 1'b1;
                end else begin
                    do_pop = 1'b1;
                end
            end
        end else if (call) begin
            do_push = 1'b1;
        end
`ifdef CRADR_SEQ_DIAG_EN
        // diagJump only steers the address; stack activity decoded above
        // still takes place.
        if (diagJump) begin
            adr_next = diag_adr_reg;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cradr_reg  <= '0;
            top_reg    <= '0;
            depth_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            parity_reg <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (!hold) begin
            cradr_reg  <= adr_next;
            parity_reg <= ^{call, ret, dispEn, dispVal};
            if (set_unf) begin
                unf_reg <= 1'b1;
            end
            if (do_push) begin
                // The ring wraps, so a push when full overwrites the oldest entry.
                stack_mem[top_inc] <= cradr_reg;
                top_reg            <= top_inc;
                if (stack_full) begin
                    ovf_reg <= 1'b1;
                end else begin
                    depth_reg <= depth_reg + 1'b1;
                end
            end else if (do_pop) begin
                top_reg   <= top_reg - 1'b1;
                depth_reg <= depth_reg - 1'b1;
            end else if (do_replace) begin
                stack_mem[top_reg] <= cradr_reg;
            end
        end
    end

    assign CRADR      = cradr_reg;
    assign sbrRet     = stack_empty ? '0 : top_val;
    assign depth      = depth_reg;
    assign stackOvf   = ovf_reg;
    assign stackUnf   = unf_reg;
    assign dispParity = parity_reg;

`ifdef CRADR_SEQ_DIAG_EN
    // Diagnostic load and readback run regardless of hold.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            diag_adr_reg <= '0;
            drive_reg    <= 1'b0;
            ebus_out_reg <= '0;
        end else begin
            if (diagLoad) begin
                diag_adr_reg <= ebusIn[36-ADR_W:35];
            end
            drive_reg    <= diagRead;
            ebus_out_reg <= diagRead ? {{(36-ADR_W){1'b0}}, cradr_reg} : '0;
        end
    end

    assign drivingEBUS = drive_reg;
    assign ebusOut     = ebus_out_reg;

    // Only the low ADR_W EBUS bits carry an address.
    logic unused_ebus_hi;
    assign unused_ebus_hi = ^ebusIn[0:35-ADR_W];
`else
    assign drivingEBUS = 1'b0;
    assign ebusOut     = '0;

    logic unused_diag;
    assign unused_diag = ^{diagLoad, diagJump, diagRead, ebusIn};
`endif

endmodule

// File: doc/cradr_seq.md
CRADR_SEQ -- requirements
Module: cradr_seq

Interface
REQ-001 SHALL have parameter ADR_W, default 11, width of the CRAM address.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, number of CALL/RETURN stack entries (power of two, 2..64).
REQ-003 SHALL have parameter DISP_W, default 5, width of the dispatch OR-field; DISP_W <= ADR_W.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- hold  in  1  stall; when 1, no state changes except diagnostic load and readback.
- J  in  ADR_W  microinstruction jump field.
- dispEn  in  1  OR dispVal into the low bits of the next address.
- dispVal  in  DISP_W  dispatch value.
- call  in  1  push the current address.
- ret  in  1  pop the stack and return.
- force1777  in  1  page-fail trap: force the next address to all ones.
- diagLoad  in  1  load diagAdr from ebusIn[36-ADR_W:35].
- diagJump  in  1  take diagAdr as the next address.
- diagRead  in  1  request EBUS readback.
- ebusIn  in  36  EBUS data.
- CRADR  out  ADR_W  registered current CRAM address.
- sbrRet  out  ADR_W  stack top, 0 when empty.
- depth  out  $clog2(STACK_DEPTH)+1  occupancy.
- stackOvf  out  1  sticky overflow flag.
- stackUnf  out  1  sticky underflow flag.
- dispParity  out  1  registered odd parity of {call, ret, dispEn, dispVal}.
- drivingEBUS  out  1  high while ebusOut is valid.
- ebusOut  out  36  readback data.

Function
REQ-005 SHALL update CRADR once per cycle when hold=0, with next-address priority: diagJump, then force1777, then ret, then the default.
REQ-006 SHALL use next address (J | zero-extended dispVal) by default when dispEn=1, and J when dispEn=0.
REQ-007 SHALL, on ret, use next address (popped top | J) and decrement depth.
REQ-008 SHALL, on force1777, use next address all ones and push the current CRADR regardless of call.
REQ-009 SHALL, on call without ret, push the current CRADR and increment depth.
REQ-010 SHALL, on call and ret in the same cycle, replace the top entry with CRADR, take next = old top | J, and leave depth unchanged.
REQ-011 SHALL, on a push at depth=STACK_DEPTH, overwrite the oldest entry (circular), keep depth at maximum, and set stackOvf.
REQ-012 SHALL, on ret at depth=0, take next = J, leave depth at 0, and set stackUnf.
REQ-013 SHALL clear stackOvf and stackUnf only by reset.
REQ-014 SHALL present sbrRet combinationally from the stack top after the current edge.
REQ-015 SHALL register dispParity every cycle in which hold=0.
REQ-016 SHALL, with hold=1, freeze CRADR, the stack, depth, the flags and dispParity, and ignore call, ret and force1777.

Reset
REQ-017 SHALL asynchronously set CRADR=0, depth=0, sbrRet=0, stackOvf=0, stackUnf=0, dispParity=0, drivingEBUS=0, ebusOut=0 and diagAdr=0 when resetN=0.
REQ-018 SHALL, on reset assertion mid-call or mid-readback, abandon the operation, with no partial push and drivingEBUS deasserted immediately.

Configuration
REQ-019 SHALL compile diagnostic logic (diagAdr, diagLoad, diagJump, diagRead, drivingEBUS, ebusOut) only when macro CRADR_SEQ_DIAG_EN is defined.
REQ-020 SHALL, with CRADR_SEQ_DIAG_EN:
- load diagAdr on diagLoad even while hold=1.
- on diagRead, drive ebusOut = {zeros, CRADR} and drivingEBUS=1 on the next cycle, holding both for exactly one cycle.
REQ-021 SHALL, without CRADR_SEQ_DIAG_EN, ignore the diagnostic inputs and tie drivingEBUS=0 and ebusOut=0.

Verification
REQ-022 SHALL cover: reset, then J=11'o0100, dispEn=1, dispVal=5'o07 -> CRADR=11'o0107 after one edge.
REQ-023 SHALL cover: CRADR=11'o0200, call=1, J=11'o0300 -> CRADR=11'o0300, sbrRet=11'o0200, depth=1; then ret=1, J=11'o0001 -> CRADR=11'o0201, depth=0.
REQ-024 SHALL cover: nine consecutive calls with STACK_DEPTH=8 -> depth=8, stackOvf=1, first-pushed entry lost; eight rets return in LIFO order.
REQ-025 SHALL cover: ret at depth 0 with J=11'o0042 -> CRADR=11'o0042 and stackUnf=1 persisting until reset.
REQ-026 SHALL cover: force1777 with CRADR=11'o0555 -> CRADR=11'o3777 and sbrRet=11'o0555; force1777 together with ret -> force1777 wins and no pop occurs.
REQ-027 SHALL cover (DIAG_EN): diagLoad with ebusIn[25:35]=11'o1234, then diagJump -> CRADR=11'o1234; diagRead -> drivingEBUS=1 for one cycle with ebusOut[25:35]=11'o1234.
